memory_port_arbiter: RTL and testbench

Two-requester arbiter sharing the core's single 16-bit memory bus between the instruction prefetcher and the execution unit's data port. Sits between both requesters and the bus interface unit. One transaction in flight at a time; ownership registered and held until the bus acknowledges. Data accesses have fixed priority, with optional anti-starvation for instruction fetch.

---
 rtl/memory_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_memory_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
// Shares the single 16-bit memory bus between the instruction prefetcher and
// the execution unit's data port. One transaction is in flight at a time.
// Bus ownership is registered when the request is granted. It is held until
// the bus acknowledges the transaction.
// Data accesses win by fixed priority.
// Optional macro MEM_ARB_FAIRNESS_EN enables a starvation counter. When it
// reaches STARVE_LIMIT, a contested grant goes to instruction fetch instead.
module memory_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  input  logic [19:1] instr_m_addr,
  output logic [15:0] instr_m_data_in,
  input  logic        data_m_access,
  output logic        data_m_ack,
  input  logic [19:1] data_m_addr,
  output logic [15:0] data_m_data_in,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic [19:1] q_m_addr,
  input  logic [15:0] q_m_data_in,
  output logic [15:0] q_m_data_out,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  output logic        q_owner_data
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_DATA  = 2'd1,
    OWN_INSTR = 2'd2
  } owner_t;

  owner_t owner_r;
  owner_t owner_next_s;
  logic   instr_win_s;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam logic [2:0] LIMIT_W = 3'(STARVE_LIMIT);

  logic [2:0] starve_cnt_r;

  // Instruction fetch overrides data priority once it has been starved enough
  always_comb begin
    if (instr_m_access && data_m_access && (starve_cnt_r >= LIMIT_W)) begin
      instr_win_s = 1'b1;
    end else begin
      instr_win_s = 1'b0;
    end
  end

  // Count contested data grants (saturating), clear on any instruction grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_r <= 3'd0;
    end else if ((owner_r == OWN_NONE) && (owner_next_s == OWN_INSTR)) begin
      starve_cnt_r <= 3'd0;
    end else if ((owner_r == OWN_NONE) && (owner_next_s == OWN_DATA) &&
                 instr_m_access && (starve_cnt_r != 3'd7)) begin
      starve_cnt_r <= starve_cnt_r + 3'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  logic unused_cfg_s;

  // Strict data priority: instruction fetch never overrides
  always_comb begin
    instr_win_s  = 1'b0;
    unused_cfg_s = (STARVE_LIMIT == 32'd0);
  end
`endif

  // Ownership register; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_r <= OWN_NONE;
    end else begin
      owner_r <= owner_next_s;
    end
  end

  // Arbitrate in NONE; otherwise hold ownership until the bus acknowledges
  always_comb begin
    owner_next_s = owner_r;
    case (owner_r)
      OWN_NONE: begin
        if (data_m_access && !instr_win_s) begin
          owner_next_s = OWN_DATA;
        end else if (instr_m_access) begin
          owner_next_s = OWN_INSTR;
        end else begin
          owner_next_s = OWN_NONE;
        end
      end
      OWN_DATA, OWN_INSTR: begin
        if (q_m_ack) begin
          owner_next_s = OWN_NONE;
        end else begin
          owner_next_s = owner_r;
        end
      end
      default: owner_next_s = OWN_NONE;
    endcase
  end

  // Bus mux and ack routing, driven by the registered owner
  always_comb begin
    q_m_access      = 1'b0;
    q_m_addr        = 19'd0;
    q_m_data_out    = 16'd0;
    q_m_wr_en       = 1'b0;
    q_m_bytesel     = 2'b00;
    instr_m_ack     = 1'b0;
    data_m_ack      = 1'b0;
    q_owner_data    = 1'b0;
    instr_m_data_in = q_m_data_in;
    data_m_data_in  = q_m_data_in;
    case (owner_r)
      OWN_DATA: begin
        q_m_access   = data_m_access;
        q_m_addr     = data_m_addr;
        q_m_data_out = data_m_data_out;
        q_m_wr_en    = data_m_wr_en;
        q_m_bytesel  = data_m_bytesel;
        data_m_ack   = q_m_ack;
        q_owner_data = 1'b1;
      end
      OWN_INSTR: begin
        q_m_access   = instr_m_access;
        q_m_addr     = instr_m_addr;
        q_m_bytesel  = 2'b11;
        instr_m_ack  = q_m_ack;
      end
      default: begin
        q_m_access = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter. Compile with MEM_ARB_FAIRNESS_EN
// to exercise the anti-starvation path.
module tb_memory_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_m_access = 1'b0;
  logic        instr_m_ack;
  logic [19:1] instr_m_addr = 19'd0;
  logic [15:0] instr_m_data_in;
  logic        data_m_access = 1'b0;
  logic        data_m_ack;
  logic [19:1] data_m_addr = 19'd0;
  logic [15:0] data_m_data_in;
  logic [15:0] data_m_data_out = 16'd0;
  logic        data_m_wr_en = 1'b0;
  logic [1:0]  data_m_bytesel = 2'b00;
  logic        q_m_access;
  logic        q_m_ack = 1'b0;
  logic [19:1] q_m_addr;
  logic [15:0] q_m_data_in = 16'd0;
  logic [15:0] q_m_data_out;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic        q_owner_data;

  int total = 0;
  int bad = 0;
  int first_instr;
  int instr_grants;
  int exp_first;
  int exp_grants;

  memory_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .instr_m_access(instr_m_access), .instr_m_ack(instr_m_ack),
    .instr_m_addr(instr_m_addr), .instr_m_data_in(instr_m_data_in),
    .data_m_access(data_m_access), .data_m_ack(data_m_ack),
    .data_m_addr(data_m_addr), .data_m_data_in(data_m_data_in),
    .data_m_data_out(data_m_data_out), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel),
    .q_m_access(q_m_access), .q_m_ack(q_m_ack), .q_m_addr(q_m_addr),
    .q_m_data_in(q_m_data_in), .q_m_data_out(q_m_data_out),
    .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel),
    .q_owner_data(q_owner_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #1 reset = 1'b1;
    tick();
    tick();
    chk("rst_access", 32'(q_m_access), 32'd0);
    chk("rst_addr", 32'(q_m_addr), 32'd0);
    chk("rst_dout", 32'(q_m_data_out), 32'd0);
    chk("rst_wr_bsel", 32'({q_m_wr_en, q_m_bytesel}), 32'd0);
    chk("rst_acks", 32'({instr_m_ack, data_m_ack, q_owner_data}), 32'd0);
    reset = 1'b0;
    tick();

    // lone instruction fetch
    instr_m_access = 1'b1;
    instr_m_addr = 19'h0FFF0;
    #1;
    chk("i_latency", 32'(q_m_access), 32'd0);
    tick();
    chk("i_access", 32'(q_m_access), 32'd1);
    chk("i_addr", 32'(q_m_addr), 32'h0FFF0);
    chk("i_wr_bsel", 32'({q_m_wr_en, q_m_bytesel}), 32'h3);
    chk("i_dout", 32'(q_m_data_out), 32'd0);
    chk("i_owner", 32'(q_owner_data), 32'd0);
    q_m_ack = 1'b1;
    q_m_data_in = 16'hBEEF;
    #1;
    chk("i_acks", 32'({instr_m_ack, data_m_ack}), 32'h2);
    chk("i_rdata", 32'(instr_m_data_in), 32'hBEEF);
    tick();
    instr_m_access = 1'b0;
    q_m_ack = 1'b0;
    #1;
    chk("i_after", 32'({q_m_access, instr_m_ack}), 32'd0);

    // data write
    data_m_access = 1'b1;
    data_m_addr = 19'h00100;
    data_m_data_out = 16'h1234;
    data_m_wr_en = 1'b1;
    data_m_bytesel = 2'b01;
    tick();
    chk("d_access", 32'(q_m_access), 32'd1);
    chk("d_addr", 32'(q_m_addr), 32'h00100);
    chk("d_dout", 32'(q_m_data_out), 32'h1234);
    chk("d_wr_bsel", 32'({q_m_wr_en, q_m_bytesel}), 32'h5);
    chk("d_owner", 32'(q_owner_data), 32'd1);
    tick();
    chk("d_hold", 32'({q_owner_data, data_m_ack}), 32'h2);
    q_m_ack = 1'b1;
    #1;
    chk("d_acks", 32'({instr_m_ack, data_m_ack}), 32'h1);
    tick();
    data_m_access = 1'b0;
    data_m_wr_en = 1'b0;
    q_m_ack = 1'b0;
    #1;
    chk("d_released", 32'({q_owner_data, q_m_access}), 32'd0);

    // simultaneous requests: data first, then instr after a dead cycle
    data_m_access = 1'b1;
    data_m_addr = 19'h00200;
    data_m_bytesel = 2'b11;
    instr_m_access = 1'b1;
    instr_m_addr = 19'h00300;
    tick();
    chk("both_data_addr", 32'(q_m_addr), 32'h00200);
    chk("both_data_owner", 32'(q_owner_data), 32'd1);
    q_m_ack = 1'b1;
    #1;
    chk("both_data_ack", 32'({instr_m_ack, data_m_ack}), 32'h1);
    tick();
    data_m_access = 1'b0;
    q_m_ack = 1'b0;
    #1;
    chk("both_dead", 32'(q_m_access), 32'd0);
    tick();
    chk("both_instr_addr", 32'(q_m_addr), 32'h00300);
    chk("both_instr_access", 32'({q_m_access, q_owner_data}), 32'h2);
    q_m_ack = 1'b1;
    #1;
    chk("both_instr_ack", 32'({instr_m_ack, data_m_ack}), 32'h2);
    tick();
    q_m_ack = 1'b0;

    // continuous data with instruction pending
    data_m_access = 1'b1;
    instr_m_access = 1'b1;
    first_instr = -1;
    instr_grants = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("starve_grant", 32'(q_m_access), 32'd1);
      if (q_owner_data == 1'b0) begin
        instr_grants++;
        if (first_instr < 0) first_instr = i;
      end
      q_m_ack = 1'b1;
      #1;
      tick();
      q_m_ack = 1'b0;
    end
`ifdef MEM_ARB_FAIRNESS_EN
    exp_first = 4;
    exp_grants = 4;
`else
    exp_first = -1;
    exp_grants = 0;
`endif
    chk("starve_first", 32'(first_instr), 32'(exp_first));
    chk("starve_count", 32'(instr_grants), 32'(exp_grants));
    instr_m_access = 1'b0;
    data_m_access = 1'b0;
    tick();

    // reset mid-transaction
    data_m_access = 1'b1;
    data_m_addr = 19'h00444;
    tick();
    chk("mid_owned", 32'({q_m_access, q_owner_data}), 32'h3);
    instr_m_access = 1'b1;
    instr_m_addr = 19'h00555;
    q_m_ack = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid_rst_bus", 32'({q_m_access, q_owner_data, q_m_wr_en, q_m_bytesel}), 32'd0);
    chk("mid_rst_addr", 32'(q_m_addr), 32'd0);
    chk("mid_rst_acks", 32'({instr_m_ack, data_m_ack}), 32'd0);
    q_m_ack = 1'b0;
    data_m_access = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_idle", 32'(q_m_access), 32'd0);
    tick();
    chk("post_rst_instr", 32'({q_m_access, q_owner_data}), 32'h2);
    chk("post_rst_addr", 32'(q_m_addr), 32'h00555);
    q_m_ack = 1'b1;
    #1;
    tick();
    q_m_ack = 1'b0;
    instr_m_access = 1'b0;

    // spurious ack while idle
    tick();
    q_m_ack = 1'b1;
    #1;
    chk("spur_acks", 32'({instr_m_ack, data_m_ack}), 32'd0);
    tick();
    chk("spur_idle", 32'({q_m_access, q_owner_data}), 32'd0);
    q_m_ack = 1'b0;
    data_m_access = 1'b1;
    data_m_addr = 19'h00777;
    tick();
    chk("spur_then_grant", 32'({q_m_access, q_owner_data}), 32'h3);
    q_m_ack = 1'b1;
    #1;
    tick();
    q_m_ack = 1'b0;
    data_m_access = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
